// File: rtl/dr_join_handshake.sv
// dr_join_handshake: N-channel dual-rail completion detector with 4-phase handshake join,
// plus illegal-code, partial-input timeout and token-count detection.
module dr_join_handshake #(
    parameter int NCH     = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH*W-1:0]   dt,
    input  logic [NCH*W-1:0]   df,
    input  logic [NCH-1:0]     ch_en,
    input  logic               ack_nxt,
    input  logic               err_clr,
    output logic               ack_prev,
    output logic               valid_out,
    output logic [NCH*W-1:0]   data_out,
    output logic               inv,
    output logic               err_illegal,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   tok_cnt
);
    typedef enum logic [1:0] {S_NULL, S_DATA, S_RTZ} state_t;
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO = TW'(TIMEOUT);
    localparam int C1 = NCH > 1 ? 1 : 0;
    state_t state, state_n;
    logic [NCH-1:0] rv, rn, ri, en, en_q, en_n;
    logic [NCH*W-1:0] dmask, data_n;
    logic [TW-1:0] timer, timer_n;
    logic [CNT_W-1:0] cnt_n;
    logic ack_n, val_n, ill_n, to_n;
    logic all_valid, all_null, any_ill, partial;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign rv[i] = &(dt[i*W +: W] ^ df[i*W +: W]);
        assign rn[i] = ~|(dt[i*W +: W] | df[i*W +: W]);
        assign ri[i] = |(dt[i*W +: W] & df[i*W +: W]);
        assign dmask[i*W +: W] = {W{ch_en[i]}};
    end
    // ch_en is live only while idle; a token in flight is judged against the captured mask
    assign en        = (state == S_NULL) ? ch_en : en_q;
    assign all_valid = &(rv | ~en);
    assign all_null  = &(rn | ~en);
    assign any_ill   = |(ri & en);
    assign partial   = !all_null && !all_valid && !any_ill;
    assign inv       = rv[0] & rv[C1];
    always_comb begin
        state_n = state;
        ack_n   = ack_prev;
        val_n   = valid_out;
        data_n  = data_out;
        en_n    = en_q;
        cnt_n   = tok_cnt;
        timer_n = (state == S_NULL && partial) ? ((timer == TO) ? timer : timer + TW'(1)) : '0;
        ill_n   = any_ill || (err_illegal && !err_clr);
        to_n    = (TIMEOUT != 0 && state == S_NULL && partial && timer_n == TO) ||
                  (err_timeout && !err_clr);
        case (state)
            S_NULL: begin
                en_n = ch_en;
                if (all_valid && !any_ill && !ack_nxt) begin
                    data_n  = dt & dmask;
                    val_n   = 1'b1;
                    cnt_n   = tok_cnt + CNT_W'(1);
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (ack_nxt) begin
                    val_n   = 1'b0;
                    ack_n   = 1'b1;
                    state_n = S_RTZ;
                end
            end
            S_RTZ: begin
                if (all_null && !ack_nxt) begin
                    ack_n   = 1'b0;
                    state_n = S_NULL;
                end
            end
            default: state_n = S_NULL;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_NULL;
            ack_prev    <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            en_q        <= '1;
            tok_cnt     <= '0;
            timer       <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            ack_prev    <= ack_n;
            valid_out   <= val_n;
            data_out    <= data_n;
            en_q        <= en_n;
            tok_cnt     <= cnt_n;
            timer       <= timer_n;
            err_illegal <= ill_n;
            err_timeout <= to_n;
        end
    end
endmodule

// File: tb/tb_dr_join_handshake.sv
// tb_dr_join_handshake: directed scenarios then random traffic, every cycle compared
// against a bit-level behavioural model of the join.
module tb_dr_join_handshake;
    localparam int NCH = 4, W = 8, TOUT = 4, CW = 4;
    logic clk = 0, reset = 1, ack_nxt = 0, err_clr = 0;
    logic [31:0] dt = 0, df = 0, data_out;
    logic [3:0] ch_en = 4'hF, tok_cnt;
    logic ack_prev, valid_out, inv, err_illegal, err_timeout;
    int checks = 0, errors = 0;
    int m_phase, m_timer, m_cnt;
    bit m_ack, m_valid, m_ill, m_to, m_inv;
    bit [3:0] m_en;
    bit [31:0] m_data;

    always #5 clk = ~clk;

    dr_join_handshake #(.NCH(NCH), .W(W), .TIMEOUT(TOUT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .dt(dt), .df(df), .ch_en(ch_en), .ack_nxt(ack_nxt),
        .err_clr(err_clr), .ack_prev(ack_prev), .valid_out(valid_out), .data_out(data_out),
        .inv(inv), .err_illegal(err_illegal), .err_timeout(err_timeout), .tok_cnt(tok_cnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bit-by-bit classification of the dual-rail word under a channel mask
    task automatic classify(input bit [3:0] mask, output bit av, output bit an, output bit ai);
        av = 1; an = 1; ai = 0;
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < W; b++) begin
                bit t, f;
                t = dt[c*W+b];
                f = df[c*W+b];
                if (mask[c]) begin
                    if (t && f) ai = 1;
                    if (t == f) av = 0;
                    if (t || f) an = 0;
                end
            end
    endtask

    task automatic model;
        bit av, an, ai, v0, v1, n0, n1, i0, i1, part;
        bit [3:0] mask;
        classify(4'b0001, v0, n0, i0);
        classify(4'b0010, v1, n1, i1);
        m_inv = v0 && v1;
        if (reset) begin
            m_phase = 0; m_ack = 0; m_valid = 0; m_data = 0; m_ill = 0; m_to = 0;
            m_cnt = 0; m_timer = 0; m_en = 4'hF;
            return;
        end
        mask = (m_phase == 0) ? ch_en : m_en;
        classify(mask, av, an, ai);
        part = !an && !av && !ai;
        m_timer = (m_phase == 0 && part) ? ((m_timer < TOUT) ? m_timer + 1 : TOUT) : 0;
        m_ill = ai || (m_ill && !err_clr);
        m_to = (m_phase == 0 && part && m_timer == TOUT) || (m_to && !err_clr);
        if (m_phase == 0) begin
            m_en = ch_en;
            if (av && !ai && !ack_nxt) begin
                for (int c = 0; c < NCH; c++) m_data[c*W +: W] = ch_en[c] ? dt[c*W +: W] : 8'h00;
                m_valid = 1; m_cnt = (m_cnt + 1) % 16; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack_nxt) begin m_valid = 0; m_ack = 1; m_phase = 2; end
        end else if (an && !ack_nxt) begin
            m_ack = 0; m_phase = 0;
        end
    endtask

    task automatic step;
        model();
        @(posedge clk);
        #1;
        check("ack_prev", 32'(ack_prev), 32'(m_ack));
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("data_out", data_out, m_data);
        check("inv", 32'(inv), 32'(m_inv));
        check("err_illegal", 32'(err_illegal), 32'(m_ill));
        check("err_timeout", 32'(err_timeout), 32'(m_to));
        check("tok_cnt", 32'(tok_cnt), 32'(m_cnt));
    endtask

    task automatic put(input bit [31:0] t, input bit [31:0] f);
        dt = t; df = f;
    endtask

    task automatic token(input bit [31:0] v);
        put(v, ~v); ack_nxt = 0; step();
        ack_nxt = 1; step();
        put(0, 0); step();
        ack_nxt = 0; step();
    endtask

    initial begin
        bit [31:0] t, f;
        reset = 1; step(); step();
        reset = 0;
        // basic token
        put({4{8'hA5}}, ~{4{8'hA5}}); step();
        check("t1_data", data_out, 32'hA5A5_A5A5);
        check("t1_valid", 32'(valid_out), 32'd1);
        ack_nxt = 1; step();
        check("t1_ack", 32'(ack_prev), 32'd1);
        put(0, 0); ack_nxt = 0; step();
        check("t1_rtz", 32'(ack_prev), 32'd0);
        // partial enable: channels 2,3 null
        ch_en = 4'b0011; put(32'h0000_3C5A, 32'h0000_C3A5); step();
        check("t2_data", data_out, 32'h0000_3C5A);
        ack_nxt = 1; step(); put(0, 0); ack_nxt = 0; step();
        ch_en = 4'hF;
        // illegal bit blocks capture until fixed
        t = 32'h1234_5678; f = ~t; t[11] = 1; f[11] = 1; put(t, f); step();
        check("t3_ill", 32'(err_illegal), 32'd1);
        check("t3_nocap", 32'(valid_out), 32'd0);
        f[11] = ~t[11]; t[11] = 1; f[11] = 0; put(t, f); step();
        check("t3_cap", 32'(valid_out), 32'd1);
        err_clr = 1; step(); err_clr = 0;
        check("t3_clr", 32'(err_illegal), 32'd0);
        ack_nxt = 1; step(); put(0, 0); ack_nxt = 0; step();
        // timeout after 4 partial cycles
        put(32'h0000_00C3, 32'h0000_003C);
        repeat (3) step();
        check("t4_early", 32'(err_timeout), 32'd0);
        step();
        check("t4_to", 32'(err_timeout), 32'd1);
        put(0, 0); err_clr = 1; step(); err_clr = 0;
        // stall while ack_nxt high
        ack_nxt = 1; put(32'h0F0F_F0F0, 32'hF0F0_0F0F); step();
        check("t5_stall", 32'(valid_out), 32'd0);
        ack_nxt = 0; step();
        check("t5_go", 32'(valid_out), 32'd1);
        // reset in S_DATA
        reset = 1; step(); reset = 0;
        check("t6_data_rst", 32'(tok_cnt), 32'd0);
        // reset in S_RTZ
        put(32'h5555_5555, 32'hAAAA_AAAA); step(); ack_nxt = 1; step();
        reset = 1; ack_nxt = 0; step(); reset = 0;
        check("t6_rtz_rst", 32'(ack_prev), 32'd0);
        put(0, 0); step();
        // wrap of 4-bit counter
        for (int i = 0; i < 17; i++) token($urandom);
        check("wrap", 32'(tok_cnt), 32'd1);
        // random traffic
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                bit [7:0] v, m;
                int r;
                v = 8'($urandom); m = 8'($urandom);
                r = $urandom_range(0, 9);
                if (r < 4) begin t[c*W +: W] = v; f[c*W +: W] = ~v; end
                else if (r < 7) begin t[c*W +: W] = 0; f[c*W +: W] = 0; end
                else if (r < 9) begin t[c*W +: W] = v & m; f[c*W +: W] = ~v & m; end
                else begin t[c*W +: W] = v | m; f[c*W +: W] = ~v | m; end
            end
            put(t, f);
            ack_nxt = ($urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            ch_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
